baud_ctrl: RTL
==============

# baud_ctrl

Programmable baud-tick controller for the UART. Generates a 16x-oversample receive tick and a 1x transmit tick from the system clock using a runtime-configurable divisor. Accepts divisor changes over a valid/ready handshake and defers each change until both the transmitter and receiver are idle. Sits between the register interface and the UART TX/RX engines, and replaces the free-running fixed-divisor clock generator.

## Interface
- `DIV_W`, 16: width of the divisor and of the divide counter.
- `DEFAULT_DIV`, 27: reset divisor (50 MHz / (115200 × 16) ≈ 27). Must satisfy 2 ≤ `DEFAULT_DIV` < 2^`DIV_W`.
- `OVERSAMPLE`, 16: number of `tick_rx` pulses per `tick_tx` pulse. Must be ≥ 2.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  tick generation enable.
- `cfg_div`  in  `DIV_W`  requested divisor, in `clk_in` cycles per `tick_rx`.
- `cfg_valid`  in  1  `cfg_div` is valid.
- `cfg_ready`  out  1  the block can accept a new divisor.
- `cfg_err`  out  1  one-cycle pulse: an offered divisor was rejected.
- `tx_busy`  in  1  transmitter mid-frame.
- `rx_busy`  in  1  receiver mid-frame.
- `tick_rx`  out  1  one-cycle oversample tick.
- `tick_tx`  out  1  one-cycle bit tick.
- `div_active`  out  `DIV_W`  divisor currently in use.
- `pending`  out  1  an accepted divisor is waiting to be applied.

## Operation
- **Divide counter `div_cnt`:** counts 0 to `div_active`−1.
- **Oversample counter `os_cnt`:** counts 0 to `OVERSAMPLE`−1 and advances only on a `div_cnt` wrap.
- **State machine, states DISABLED, RUN, PEND:**
  - DISABLED → RUN when `enable`=1 and `pending`=0.
  - DISABLED → PEND when `enable`=1 and `pending`=1.
  - RUN → PEND on an accepted configuration.
  - PEND → RUN on apply.
  - RUN or PEND → DISABLED when `enable`=0. `pending` is retained.
- **Accept:** when `cfg_valid`=1, `cfg_ready`=1 and `cfg_div` ≥ 2, capture `cfg_div` into `div_next` and set `pending`.
  - `cfg_ready` = !`pending`.
- **Reject:** when `cfg_valid`=1, `cfg_ready`=1 and `cfg_div` < 2:
  - pulse `cfg_err` for one cycle;
  - capture nothing;
  - `cfg_ready` stays 1.
- **Apply condition:** `pending`=1 and (`enable`=0 or (`tx_busy`=0 and `rx_busy`=0)). When it holds:
  - `div_active` ← `div_next`;
  - `pending` ← 0;
  - `div_cnt` ← 0, `os_cnt` ← 0;
  - `tick_rx` and `tick_tx` are 0 that cycle.
- **`enable`=0:** `div_cnt` and `os_cnt` are held at 0 and both ticks are 0.
- **Arithmetic:** `div_cnt` is unsigned `DIV_W` bits, compared with `div_active`−1. No overflow is possible because `div_active` ≥ 2.

## Timing
- **Reset values:**
  - `div_active`=`DEFAULT_DIV`;
  - `div_cnt`=0, `os_cnt`=0;
  - `tick_rx`=0, `tick_tx`=0;
  - `pending`=0, `cfg_ready`=1, `cfg_err`=0;
  - state DISABLED.
- **Registered outputs:** every output is registered.
- **`tick_rx`:** high for the one cycle after the edge at which `enable`=1 and `div_cnt`=`div_active`−1.
- **First tick:** after `enable` rises, the first `tick_rx` is high `div_active` cycles later. Pulses then repeat with period `div_active`.
- **`tick_tx`:** coincident with every `OVERSAMPLE`-th `tick_rx`, i.e. the `tick_rx` on which `os_cnt` wraps. Period is `div_active`×`OVERSAMPLE`.
- **Accept latency:** a divisor accepted at edge k gives `pending`=1 and `cfg_ready`=0 from k. The earliest apply is at edge k+1.
- **Priority:** apply takes precedence over a simultaneous counter wrap, so the tick is suppressed.
- **Busy wait:** if `tx_busy` or `rx_busy` is high, the old divisor keeps ticking unchanged until both are low.
- **`enable` falling:** at the next edge the counters clear and the ticks drop.
- **Async reset mid-frame:** all state returns to reset values immediately. An un-applied `div_next` is discarded.

## Structure
- **Package `baud_pkg`:**
  - state enum (`ST_DISABLED`, `ST_RUN`, `ST_PEND`);
  - `DEFAULT_DIV`, `OVERSAMPLE`, `DIV_W` defaults;
  - minimum legal divisor constant (2).
- **Sub-module `baud_tick_counter`:**
  - contains `div_cnt`, `os_cnt` and tick generation;
  - inputs: `enable`, `clear`, `div_active`.
- **Top level:** `baud_ctrl` holds the FSM, the configuration handshake and the apply logic.

## Test plan
- **Reset defaults:** reset, then `enable`=1, defaults → `tick_rx` every 27 cycles, first one 27 cycles after enable; `tick_tx` every 432 cycles; `div_active`=27.
- **Idle change:** offer `cfg_div`=10 with busy low → accepted; `pending` high for 1 cycle; ticks then every 10 cycles from 0; `tick_tx` every 160 cycles.
- **Deferred change:** offer `cfg_div`=8 while `tx_busy`=1 for 200 cycles → period stays 27 and `cfg_ready`=0; 8 is applied the cycle after `tx_busy` falls; a second `cfg_valid` during the wait is not accepted.
- **Illegal divisor:** `cfg_div`=0, then `cfg_div`=1 → `cfg_err` pulses once each; `div_active` unchanged; `cfg_ready` stays 1.
- **Disable:** `enable` dropped mid-count → no ticks from the next edge; re-enable → first `tick_rx` exactly `div_active` cycles later.
- **Reset during pending:** assert `rst_n`=0 while `pending`=1 → on release `div_active`=27, `pending`=0, no ticks until enabled.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared types and default constants for the UART baud-tick controller.
package baud_pkg;

  // Controller states: ticking stopped, ticking, ticking with a divisor waiting to apply
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_PEND     = 2'd2
  } baud_state_e;

  // Default width of the divisor and of the divide counter
  localparam int DIV_W_DEF       = 16;
  // 50 MHz / (115200 * 16) rounds to 27
  localparam int DEFAULT_DIV_DEF = 27;
  // Receive ticks per transmit tick
  localparam int OVERSAMPLE_DEF  = 16;
  // Smallest divisor the counter can honour; anything below is rejected
  localparam int MIN_DIV         = 2;

endpackage

// File: rtl/baud_ctrl_if.sv
// Divisor configuration handshake between the register interface and the baud controller.
interface baud_ctrl_if #(
  parameter int DIV_W = baud_pkg::DIV_W_DEF
);

  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_div,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_div,
    input  cfg_valid,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/baud_tick_counter.sv
// Divide and oversample counters producing the registered rx/tx tick pulses.
module baud_tick_counter
  import baud_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_active,
  output logic             tick_rx,
  output logic             tick_tx
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             div_wrap;
  logic             os_wrap;

  assign div_wrap = (div_cnt == (div_active - DIV_W'(1)));
  assign os_wrap  = (os_cnt == OS_LAST);

  // Count system clocks per rx tick and rx ticks per tx tick; clear wins over a wrap
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      tick_rx <= 1'b0;
      tick_tx <= 1'b0;
    end else if (!enable || clear) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      tick_rx <= 1'b0;
      tick_tx <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      tick_rx <= 1'b1;
      if (os_wrap) begin
        os_cnt  <= '0;
        tick_tx <= 1'b1;
      end else begin
        os_cnt  <= os_cnt + OS_W'(1);
        tick_tx <= 1'b0;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick_rx <= 1'b0;
      tick_tx <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Programmable baud-tick controller: accepts divisor changes and applies them
// only once both the transmitter and receiver are idle (or ticking is disabled).
module baud_ctrl
  import baud_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  baud_ctrl_if.slave       cfg,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             tick_rx,
  output logic             tick_tx,
  output logic [DIV_W-1:0] div_active,
  output logic             pending
);

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

  baud_state_e      state_q;
  baud_state_e      state_d;
  logic [DIV_W-1:0] div_next;
  logic             cfg_ready_q;
  logic             cfg_err_q;
  logic             accept;
  logic             reject;
  logic             apply;
  logic             pending_d;

  assign accept    = cfg.cfg_valid && cfg_ready_q && (cfg.cfg_div >= MIN_DIV_V);
  assign reject    = cfg.cfg_valid && cfg_ready_q && (cfg.cfg_div <  MIN_DIV_V);
  assign apply     = pending && (!enable || (!tx_busy && !rx_busy));
  assign pending_d = apply ? 1'b0 : (accept ? 1'b1 : pending);

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.cfg_err   = cfg_err_q;

  // Capture accepted divisors, swap them in on apply, and flag rejected offers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_active  <= RESET_DIV;
      div_next    <= RESET_DIV;
      pending     <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      pending     <= pending_d;
      cfg_ready_q <= !pending_d;
      cfg_err_q   <= reject;
      if (accept) begin
        div_next <= cfg.cfg_div;
      end
      if (apply) begin
        div_active <= div_next;
      end
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: disable overrides everything, otherwise track whether a divisor is waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: begin
        if (enable) begin
          state_d = pending ? ST_PEND : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_DISABLED;
        end else if (accept) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!enable) begin
          state_d = ST_DISABLED;
        end else if (apply) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  baud_tick_counter #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_counter (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (apply),
    .div_active (div_active),
    .tick_rx    (tick_rx),
    .tick_tx    (tick_tx)
  );

endmodule
